// File: rtl/genius_pkg.sv
// Shared types for the Genius game: colour codes, LED patterns and the LED scheduler states.
package genius_pkg;

  typedef logic [1:0] color_t;
  typedef logic [3:0] led_t;

  typedef enum logic [2:0] {
    IDLE,
    PLAY_ON,
    PLAY_OFF,
    FAIL_ON,
    FAIL_OFF
  } led_state_e;

  localparam led_t LED_OFF = 4'b0000;
  localparam led_t LED_ALL = 4'b1111;

  function automatic led_t color2led(input color_t c);
    led_t l;
    l    = LED_OFF;
    l[c] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/genius_seq_mem.sv
// Append-only colour sequence store with a count, a user read port and a playback read port.
module genius_seq_mem
  import genius_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_en,
  input  color_t     wr_color,
  input  logic [4:0] rd_idx,
  output led_t       rd_color,
  input  logic [4:0] pb_idx,
  output led_t       pb_led,
  output logic [5:0] seq_len,
  output logic       full
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  color_t     mem_q [MAX_LEN];
  logic [5:0] count_q;

  assign full    = (count_q == 6'(MAX_LEN));
  assign seq_len = count_q;

  // The count doubles as the write pointer; clear only rewinds it, stale entries are masked on read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr) begin
      count_q <= '0;
    end else if (wr_en && !full) begin
      mem_q[count_q[AW-1:0]] <= wr_color;
      count_q                <= count_q + 6'd1;
    end
  end

  assign rd_color = ({1'b0, rd_idx} < count_q) ? color2led(mem_q[rd_idx[AW-1:0]]) : LED_OFF;
  assign pb_led   = color2led(mem_q[pb_idx[AW-1:0]]);

endmodule

// File: rtl/genius_led_sched.sv
// LED bus owner for Genius: sequence playback, failure blink and button echo on one registered output.
module genius_led_sched
  import genius_pkg::*;
#(
  parameter int TIME        = 50_000_000,
  parameter int MAX_LEN     = 32,
  parameter int FAIL_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       speed,
  input  logic       clr,
  input  logic       wr_en,
  input  color_t     wr_color,
  input  logic       play_req,
  input  logic [5:0] play_len,
  input  logic       fail,
  input  led_t       echo_btn,
  input  logic [4:0] rd_idx,
  output led_t       rd_color,
  output logic [5:0] seq_len,
  output logic       full,
  output logic       busy,
  output logic       play_done,
  output logic       fail_done,
  output led_t       leds
);

  localparam int CW = $clog2(TIME);
  localparam int BW = (FAIL_BLINKS > 1) ? $clog2(FAIL_BLINKS) : 1;

  // Phase lengths are stored as terminal counts so TIME itself never has to fit in CW bits.
  localparam logic [CW-1:0] SLOW_LAST  = CW'(TIME - 1);
  localparam logic [CW-1:0] FAST_LAST  = CW'(TIME / 2 - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(FAIL_BLINKS - 1);

  led_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] plast_q, plast_d;
  logic [4:0]    idx_q, idx_d;
  logic [5:0]    len_q, len_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          zdone_q, zdone_d;
  led_t          leds_q, leds_d;

  led_t       pb_led;
  logic [5:0] req_len;
  logic       in_fail;
  logic       phase_end;
  logic       last_entry;
  logic       last_blink;

  genius_seq_mem #(
    .MAX_LEN(MAX_LEN)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_color(wr_color),
    .rd_idx  (rd_idx),
    .rd_color(rd_color),
    .pb_idx  (idx_d),
    .pb_led  (pb_led),
    .seq_len (seq_len),
    .full    (full)
  );

  assign req_len    = (play_len < seq_len) ? play_len : seq_len;
  assign in_fail    = (state_q == FAIL_ON) || (state_q == FAIL_OFF);
  assign phase_end  = (cnt_q == (in_fail ? SLOW_LAST : plast_q));
  assign last_entry = ({1'b0, idx_q} == (len_q - 6'd1));
  assign last_blink = (blink_q == BLINK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      plast_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      blink_q <= '0;
      zdone_q <= 1'b0;
      leds_q  <= LED_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plast_q <= plast_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      blink_q <= blink_d;
      zdone_q <= zdone_d;
      leds_q  <= leds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plast_d = plast_q;
    idx_d   = idx_q;
    len_d   = len_q;
    blink_d = blink_q;
    zdone_d = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fail) begin
          state_d = FAIL_ON;
          cnt_d   = '0;
          blink_d = '0;
        end else if (play_req) begin
          len_d   = req_len;
          plast_d = speed ? FAST_LAST : SLOW_LAST;
          idx_d   = '0;
          cnt_d   = '0;
          if (req_len == 6'd0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = PLAY_ON;
          end
        end
      end
      PLAY_ON: begin
        if (fail) begin
          state_d = FAIL_ON;
          cnt_d   = '0;
          blink_d = '0;
        end else if (phase_end) begin
          state_d = PLAY_OFF;
        end
      end
      PLAY_OFF: begin
        if (fail) begin
          state_d = FAIL_ON;
          cnt_d   = '0;
          blink_d = '0;
        end else if (phase_end) begin
          if (last_entry) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = PLAY_ON;
          end
        end
      end
      FAIL_ON: begin
        if (phase_end) begin
          state_d = FAIL_OFF;
        end
      end
      FAIL_OFF: begin
        if (phase_end) begin
          if (last_blink) begin
            state_d = IDLE;
          end else begin
            blink_d = blink_q + 1'b1;
            state_d = FAIL_ON;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // LEDs follow the upcoming state; echo only runs once IDLE has lasted a full cycle.
  always_comb begin
    leds_d = LED_OFF;
    case (state_d)
      PLAY_ON: leds_d = pb_led;
      FAIL_ON: leds_d = LED_ALL;
      IDLE: begin
        if (state_q == IDLE) begin
          leds_d = echo_btn;
        end
      end
      default: leds_d = LED_OFF;
    endcase

    busy      = (state_q != IDLE);
    play_done = zdone_q || ((state_q == PLAY_OFF) && phase_end && last_entry && !fail);
    fail_done = (state_q == FAIL_OFF) && phase_end && last_blink;
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_genius_led_sched.sv
// Directed bench for genius_led_sched: a per-cycle scoreboard of {leds, busy, play_done, fail_done}.
module tb_genius_led_sched;

  localparam int T   = 10;
  localparam int ML  = 32;
  localparam int FB  = 3;

  logic       clk;
  logic       rst_n;
  logic       speed;
  logic       clr;
  logic       wr_en;
  logic [1:0] wr_color;
  logic       play_req;
  logic [5:0] play_len;
  logic       fail;
  logic [3:0] echo_btn;
  logic [4:0] rd_idx;
  logic [3:0] rd_color;
  logic [5:0] seq_len;
  logic       full;
  logic       busy;
  logic       play_done;
  logic       fail_done;
  logic [3:0] leds;

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   model[$];
  int   vectors     = 0;
  int   miscompares = 0;

  genius_led_sched #(
    .TIME       (T),
    .MAX_LEN    (ML),
    .FAIL_BLINKS(FB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .speed    (speed),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_color (wr_color),
    .play_req (play_req),
    .play_len (play_len),
    .fail     (fail),
    .echo_btn (echo_btn),
    .rd_idx   (rd_idx),
    .rd_color (rd_color),
    .seq_len  (seq_len),
    .full     (full),
    .busy     (busy),
    .play_done(play_done),
    .fail_done(fail_done),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ledOf(input int code);
    logic [3:0] one;
    one = 4'b0001;
    return one << code;
  endfunction

  function automatic logic [6:0] obsVec();
    return {leds, busy, play_done, fail_done};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input logic [6:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic pushPlay(input int len, input int p, input string tag);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < p; c++) pushExp({ledOf(model[i]), 1'b1, 1'b0, 1'b0}, tag);
      for (int c = 0; c < p; c++) pushExp({4'b0000, 1'b1, (i == len - 1) && (c == p - 1), 1'b0}, tag);
    end
    pushExp(7'b0, tag);
  endtask

  task automatic pushFail(input string tag);
    for (int b = 0; b < FB; b++) begin
      for (int c = 0; c < T; c++) pushExp({4'b1111, 1'b1, 1'b0, 1'b0}, tag);
      for (int c = 0; c < T; c++) pushExp({4'b0000, 1'b1, 1'b0, (b == FB - 1) && (c == T - 1)}, tag);
    end
    pushExp(7'b0, tag);
  endtask

  task automatic stepOne();
    exp_t e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = expQ.pop_front();
      checkOutput(e.tag, 32'(obsVec()), 32'(e.v));
    end
  endtask

  task automatic runQueue();
    while (expQ.size() > 0) begin
      stepOne();
      play_req = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic pr, input logic [5:0] pl, input logic sp);
    play_req = pr;
    play_len = pl;
    speed    = sp;
  endtask

  task automatic writeCode(input int c);
    wr_en    = 1'b1;
    wr_color = 2'(c);
    @(negedge clk);
    wr_en = 1'b0;
    if (model.size() < ML) model.push_back(c);
  endtask

  task automatic checkRead(input int idx, input string tag);
    logic [3:0] exp;
    rd_idx = 5'(idx);
    #1;
    if (idx < model.size()) exp = ledOf(model[idx]);
    else exp = 4'b0000;
    checkOutput(tag, 32'(rd_color), 32'(exp));
  endtask

  initial begin
    int clipLen;
    rst_n = 1'b0; speed = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_color = '0;
    play_req = 1'b0; play_len = '0; fail = 1'b0; echo_btn = '0; rd_idx = '0;
    #1;
    checkOutput("reset_outputs", 32'(obsVec()), 32'(0));
    checkOutput("reset_len_full", 32'({full, seq_len}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    writeCode(2); writeCode(0); writeCode(3);
    checkOutput("seq_len_3", 32'(seq_len), 32'(model.size()));
    for (int i = 0; i < 4; i++) checkRead(i, "rd_color_small");
    @(negedge clk);

    applyStimulus(1'b1, 6'd3, 1'b0);
    pushPlay(3, T, "play_slow");
    runQueue();

    applyStimulus(1'b1, 6'd3, 1'b1);
    pushPlay(3, T / 2, "play_fast");
    stepOne();
    play_req = 1'b0;
    speed    = 1'b0;
    runQueue();

    clipLen = (5 < model.size()) ? 5 : model.size();
    applyStimulus(1'b1, 6'd5, 1'b1);
    pushPlay(clipLen, T / 2, "play_clip");
    runQueue();

    applyStimulus(1'b1, 6'd0, 1'b0);
    pushExp(7'b0000010, "zlen_done");
    pushExp(7'b0000000, "zlen_idle");
    runQueue();

    echo_btn = 4'b0010;
    pushExp({4'b0010, 3'b000}, "echo");
    stepOne();
    echo_btn = 4'b0000;
    pushExp(7'b0, "echo_clear");
    stepOne();

    applyStimulus(1'b1, 6'd3, 1'b1);
    echo_btn = 4'b0100;
    pushPlay(3, T / 2, "play_hold");
    for (int i = 0; i < 31; i++) begin
      stepOne();
      if (i == 24) begin
        play_req = 1'b0;
        echo_btn = 4'b0000;
      end
    end

    applyStimulus(1'b1, 6'd3, 1'b0);
    pushPlay(3, T, "play_abort");
    while (expQ.size() > 23) void'(expQ.pop_back());
    pushFail("fail_blink");
    for (int i = 0; i < 84; i++) begin
      stepOne();
      if (i == 0) play_req = 1'b0;
      if (i == 22) fail = 1'b1;
      if (i == 25) fail = 1'b0;
    end

    clr = 1'b1; wr_en = 1'b1; wr_color = 2'd1;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    model.delete();
    checkOutput("clr_over_wr", 32'(seq_len), 32'(0));
    checkRead(0, "rd_after_clr");

    for (int i = 0; i < ML + 1; i++) begin
      writeCode((i * 3 + 1) % 4);
      if (i == ML - 2) checkOutput("full_early", 32'(full), 32'(0));
    end
    checkOutput("seq_len_sat", 32'(seq_len), 32'(model.size()));
    checkOutput("full_set", 32'(full), 32'(1));
    checkRead(ML - 1, "rd_last");
    checkRead(0, "rd_first");
    @(negedge clk);

    applyStimulus(1'b1, 6'd4, 1'b1);
    pushPlay(4, T / 2, "play_rst");
    while (expQ.size() > 7) void'(expQ.pop_back());
    runQueue();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_outputs", 32'(obsVec()), 32'(0));
    checkOutput("rst_mid_seq_len", 32'(seq_len), 32'(0));
    checkOutput("rst_mid_rd_color", 32'(rd_color), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model.delete();
    for (int i = 0; i < 5; i++) pushExp(7'b0, "post_reset");
    runQueue();
    checkOutput("post_reset_len", 32'(seq_len), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
